// File: rtl/ddr_app_rw_sched.sv
// ddr_app_rw_sched: shares one DDR application port (separate write and read
// channels) between clients c0 and c1. Each grant runs one fixed-length burst;
// simultaneous requests alternate round-robin.
// Optional feature macro: DDR_SCHED_RD_TIMEOUT_EN (abort a read burst after
// RD_TIMEOUT idle cycles and raise the sticky rd_timeout_err flag).
module ddr_app_rw_sched #(
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic                  app_clk,
  input  logic                  rst_n,
  input  logic                  c0_req,
  input  logic                  c0_wr,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  output logic                  c0_gnt,
  output logic                  c0_wdata_req,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  output logic                  c0_rdata_valid,
  output logic                  c0_done,
  input  logic                  c1_req,
  input  logic                  c1_wr,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  output logic                  c1_gnt,
  output logic                  c1_wdata_req,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic                  c1_rdata_valid,
  output logic                  c1_done,
  output logic [ADDR_WIDTH-1:0] app_addr_wr,
  output logic                  app_addr_wr_valid,
  output logic [DATA_WIDTH-1:0] app_data_wr,
  output logic                  app_data_wr_valid,
  output logic [ADDR_WIDTH-1:0] app_addr_rd,
  output logic                  app_addr_rd_valid,
  input  logic [DATA_WIDTH-1:0] app_data_rd,
  input  logic                  app_data_rd_valid,
  output logic                  busy,
  output logic                  rd_timeout_err
);

  if (BURST_LEN < 2 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("ddr_app_rw_sched: BURST_LEN must be 2..255");
  end
  if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
    $error("ddr_app_rw_sched: RD_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WDATA, WADDR, RADDR, RDATA, DONE} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              beat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  // last_gnt doubles as the owner of the burst in flight: it is written with
  // the winner on every grant and only read for arbitration while IDLE.
  logic                    last_gnt;
  logic                    req_any;
  logic                    win;
  logic                    last_beat;
  logic                    rd_beat;
  logic                    rd_tmo;
  logic [DATA_WIDTH-1:0]   wdata_sel;

  assign req_any   = c0_req | c1_req;
  assign win       = (c0_req & c1_req) ? ~last_gnt : c1_req;
  assign last_beat = (beat_cnt == 8'(BURST_LEN - 1));
  assign rd_beat   = (state == RDATA) & app_data_rd_valid;
  assign wdata_sel = last_gnt ? c1_wdata : c0_wdata;

  assign busy         = (state != IDLE);
  assign c0_wdata_req = (state == WDATA) & ~last_gnt;
  assign c1_wdata_req = (state == WDATA) & last_gnt;

`ifdef DDR_SCHED_RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  assign rd_tmo = (state == RDATA) & ~app_data_rd_valid & (idle_cnt == TW'(RD_TIMEOUT - 1));

  // Read idle counter: restarts on every returned beat and outside RDATA
  always_ff @(posedge app_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt       <= '0;
      rd_timeout_err <= 1'b0;
    end else begin
      if (state != RDATA || app_data_rd_valid) idle_cnt <= '0;
      else                                     idle_cnt <= idle_cnt + 1'b1;
      if (rd_tmo) rd_timeout_err <= 1'b1;
    end
  end
`else
  assign rd_tmo         = 1'b0;
  assign rd_timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge app_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = (win ? c1_wr : c0_wr) ? WDATA : RADDR;
      WDATA:   if (last_beat) state_nxt = WADDR;
      WADDR:   state_nxt = DONE;
      RADDR:   state_nxt = RDATA;
      RDATA: begin
        if (rd_beat && last_beat) state_nxt = DONE;
        else if (rd_tmo)          state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered datapath: grant/done pulses, app strobes, beat counting
  always_ff @(posedge app_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt          <= '0;
      addr_q            <= '0;
      last_gnt          <= 1'b1;
      c0_gnt            <= 1'b0;
      c1_gnt            <= 1'b0;
      c0_done           <= 1'b0;
      c1_done           <= 1'b0;
      c0_rdata          <= '0;
      c0_rdata_valid    <= 1'b0;
      c1_rdata          <= '0;
      c1_rdata_valid    <= 1'b0;
      app_addr_wr       <= '0;
      app_addr_wr_valid <= 1'b0;
      app_data_wr       <= '0;
      app_data_wr_valid <= 1'b0;
      app_addr_rd       <= '0;
      app_addr_rd_valid <= 1'b0;
    end else begin
      c0_gnt            <= 1'b0;
      c1_gnt            <= 1'b0;
      c0_done           <= 1'b0;
      c1_done           <= 1'b0;
      app_addr_wr_valid <= 1'b0;
      app_addr_rd_valid <= 1'b0;
      app_data_wr_valid <= (state == WDATA);
      app_data_wr       <= (state == WDATA) ? wdata_sel : '0;
      c0_rdata_valid    <= rd_beat & ~last_gnt;
      c0_rdata          <= (rd_beat & ~last_gnt) ? app_data_rd : '0;
      c1_rdata_valid    <= rd_beat & last_gnt;
      c1_rdata          <= (rd_beat & last_gnt) ? app_data_rd : '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            last_gnt <= win;
            addr_q   <= win ? c1_addr : c0_addr;
            c0_gnt   <= ~win;
            c1_gnt   <= win;
            beat_cnt <= '0;
          end
        end
        WDATA: beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        WADDR: begin
          app_addr_wr       <= addr_q;
          app_addr_wr_valid <= 1'b1;
        end
        RADDR: begin
          app_addr_rd       <= addr_q;
          app_addr_rd_valid <= 1'b1;
        end
        RDATA: begin
          if (rd_beat) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
          if (rd_tmo) begin
            beat_cnt <= '0;
            c0_done  <= ~last_gnt;
            c1_done  <= last_gnt;
          end
        end
        DONE: begin
          c0_done <= ~last_gnt;
          c1_done <= last_gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_app_rw_sched.sv
// tb_ddr_app_rw_sched: directed checks of ddr_app_rw_sched with BURST_LEN=4.
module tb_ddr_app_rw_sched;

  localparam int unsigned BL = 4;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic          app_clk = 1'b0;
  logic          rst_n;
  logic          c0_req, c0_wr, c1_req, c1_wr;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_gnt, c0_wdata_req, c0_rdata_valid, c0_done;
  logic          c1_gnt, c1_wdata_req, c1_rdata_valid, c1_done;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [AW-1:0] app_addr_wr, app_addr_rd;
  logic          app_addr_wr_valid, app_data_wr_valid, app_addr_rd_valid;
  logic [DW-1:0] app_data_wr, app_data_rd;
  logic          app_data_rd_valid;
  logic          busy, rd_timeout_err;
  logic          any_out;

  ddr_app_rw_sched #(
    .BURST_LEN(BL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(16)
  ) dut (
    .app_clk(app_clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_gnt(c0_gnt),
    .c0_wdata_req(c0_wdata_req), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata),
    .c0_rdata_valid(c0_rdata_valid), .c0_done(c0_done),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_gnt(c1_gnt),
    .c1_wdata_req(c1_wdata_req), .c1_wdata(c1_wdata), .c1_rdata(c1_rdata),
    .c1_rdata_valid(c1_rdata_valid), .c1_done(c1_done),
    .app_addr_wr(app_addr_wr), .app_addr_wr_valid(app_addr_wr_valid),
    .app_data_wr(app_data_wr), .app_data_wr_valid(app_data_wr_valid),
    .app_addr_rd(app_addr_rd), .app_addr_rd_valid(app_addr_rd_valid),
    .app_data_rd(app_data_rd), .app_data_rd_valid(app_data_rd_valid),
    .busy(busy), .rd_timeout_err(rd_timeout_err)
  );

  always #5 app_clk = ~app_clk;

  assign any_out = |{c0_gnt, c1_gnt, c0_wdata_req, c1_wdata_req, c0_rdata, c0_rdata_valid,
                     c1_rdata, c1_rdata_valid, c0_done, c1_done, app_addr_wr, app_addr_wr_valid,
                     app_data_wr, app_data_wr_valid, app_addr_rd, app_addr_rd_valid, busy,
                     rd_timeout_err};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge app_clk);
    #1;
  endtask

  // Steps until a done pulse or the budget runs out; counts stray grants.
  task automatic wait_done(input int max_cyc, output int cyc, output int extra_gnt);
    cyc = 0;
    extra_gnt = 0;
    while (cyc < max_cyc && !(c0_done || c1_done)) begin
      step();
      cyc++;
      if (c0_gnt || c1_gnt) extra_gnt++;
    end
  endtask

  // One record per cycle: inputs driven in that cycle, outputs expected after its edge.
  typedef struct packed {
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          wreq;
    logic          dwv;
    logic [DW-1:0] dw;
    logic          awv;
    logic [AW-1:0] aw;
    logic          done;
    logic          busy;
  } wvec_t;

  wvec_t wv [8];

  logic [DW-1:0] rd_d [7];
  logic          rd_v [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, extra;
    logic exp_c1;

    wv[0] = '{1'b1, 1'b1, 30'h100, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 30'h0,   1'b0, 1'b1};
    wv[1] = '{1'b0, 1'b1, 30'h100, 32'hA0, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 30'h0,   1'b0, 1'b1};
    wv[2] = '{1'b0, 1'b1, 30'h100, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0, 30'h0,   1'b0, 1'b1};
    wv[3] = '{1'b0, 1'b1, 30'h100, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b0, 30'h0,   1'b0, 1'b1};
    wv[4] = '{1'b0, 1'b1, 30'h100, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA3, 1'b0, 30'h0,   1'b0, 1'b1};
    wv[5] = '{1'b0, 1'b1, 30'h100, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 30'h100, 1'b0, 1'b1};
    wv[6] = '{1'b0, 1'b1, 30'h100, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 30'h100, 1'b1, 1'b0};
    wv[7] = '{1'b0, 1'b1, 30'h100, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 30'h100, 1'b0, 1'b0};

    rd_d = '{32'hB0, 32'h0, 32'hB1, 32'hB2, 32'h0, 32'h0, 32'hB3};
    rd_v = '{1'b1,   1'b0,  1'b1,   1'b1,   1'b0,  1'b0,  1'b1};

    rst_n = 1'b0;
    c0_req = 1'b0; c0_wr = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b0; c1_wr = 1'b0; c1_addr = '0; c1_wdata = '0;
    app_data_rd = '0; app_data_rd_valid = 1'b0;
    repeat (3) step();
    chk("reset_outputs_zero", any_out, 1'b0);
    rst_n = 1'b1;
    step();

    // c0 write burst, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      c0_req = wv[i].req; c0_wr = wv[i].wr; c0_addr = wv[i].addr; c0_wdata = wv[i].wdata;
      step();
      chk($sformatf("wr_vec%0d", i),
          {c0_gnt, c0_wdata_req, app_data_wr_valid, app_data_wr, app_addr_wr_valid, app_addr_wr,
           c0_done, busy, (c1_gnt | c1_wdata_req | c1_rdata_valid | c1_done)},
          {wv[i].gnt, wv[i].wreq, wv[i].dwv, wv[i].dw, wv[i].awv, wv[i].aw,
           wv[i].done, wv[i].busy, 1'b0});
    end

    // c1 read with gaps in the return stream
    c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 30'h200;
    step();
    chk("rd_gnt", {c1_gnt, c0_gnt}, 2'b10);
    c1_req = 1'b0;
    step();
    chk("rd_addr", {app_addr_rd_valid, app_addr_rd}, {1'b1, 30'h200});
    for (int i = 0; i < 7; i++) begin
      app_data_rd = rd_d[i]; app_data_rd_valid = rd_v[i];
      step();
      chk($sformatf("rd_beat%0d", i), {c1_done, c0_rdata_valid, c1_rdata_valid, c1_rdata},
          {1'b0, 1'b0, rd_v[i], rd_v[i] ? rd_d[i] : 32'h0});
    end
    app_data_rd_valid = 1'b0; app_data_rd = '0;
    step();
    chk("rd_done", {c1_done, c0_done, busy}, 3'b100);

    // simultaneous requests, four rounds
    for (int r = 0; r < 4; r++) begin
      exp_c1 = (r % 2 == 1);
      c0_req = 1'b1; c1_req = 1'b1; c0_wr = 1'b1; c1_wr = 1'b1;
      c0_addr = 30'h10 + 30'(r); c1_addr = 30'h20 + 30'(r);
      step();
      chk($sformatf("arb_gnt%0d", r), {c1_gnt, c0_gnt}, {exp_c1, ~exp_c1});
      c0_req = 1'b0; c1_req = 1'b0;
      wait_done(20, cyc, extra);
      chk($sformatf("arb_done%0d", r), {c1_done, c0_done, 32'(cyc), 32'(extra)},
          {exp_c1, ~exp_c1, 32'd6, 32'd0});
    end

    // stray read beats while IDLE and during a write burst
    app_data_rd = 32'hDEAD; app_data_rd_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stray_idle", {c0_rdata_valid, c1_rdata_valid, busy}, 3'b000);
    end
    c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 30'h180;
    step();
    c0_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("stray_wdata", {c0_rdata_valid, c1_rdata_valid}, 2'b00);
    end
    app_data_rd_valid = 1'b0;
    c0_req = 1'b1; c0_wr = 1'b0; c0_addr = 30'h300;
    step();
    chk("rd2_gnt", {c0_gnt, c1_gnt}, 2'b10);
    c0_req = 1'b0;
    step();
    chk("rd2_addr", {app_addr_rd_valid, app_addr_rd}, {1'b1, 30'h300});
    for (int i = 0; i < 5; i++) begin
      app_data_rd = 32'hC0 + 32'(i); app_data_rd_valid = 1'b1;
      step();
      if (i < 4)
        chk($sformatf("rd2_beat%0d", i), {c0_done, c0_rdata_valid, c0_rdata},
            {1'b0, 1'b1, 32'hC0 + 32'(i)});
      else
        chk("rd2_done", {c0_done, c0_rdata_valid, c0_rdata}, {1'b1, 1'b0, 32'h0});
    end
    app_data_rd_valid = 1'b0;
    step();
    chk("rd2_idle", {c0_done, c0_rdata_valid, busy}, 3'b000);

    // reset during beat 2 of a c0 write
    c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 30'h1C0; c0_wdata = 32'h11;
    step();
    c0_req = 1'b0; c0_wdata = 32'h22;
    step();
    chk("rst_mid_busy_before", {busy, c0_wdata_req}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs_zero", any_out, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_no_done", {c0_done, busy}, 2'b00);
    end
    c0_req = 1'b1; c1_req = 1'b1; c0_wr = 1'b1; c1_wr = 1'b1;
    step();
    chk("rst_mid_c0_first", {c0_gnt, c1_gnt}, 2'b10);
    c0_req = 1'b0; c1_req = 1'b0;
    wait_done(20, cyc, extra);
    chk("rst_mid_burst_done", {c0_done, 32'(cyc)}, {1'b1, 32'd6});

`ifdef DDR_SCHED_RD_TIMEOUT_EN
    // c1 read where only two beats come back
    c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 30'h240;
    step();
    chk("tmo_gnt", c1_gnt, 1'b1);
    c1_req = 1'b0;
    step();
    app_data_rd = 32'hE0; app_data_rd_valid = 1'b1;
    step();
    app_data_rd = 32'hE1;
    step();
    app_data_rd_valid = 1'b0;
    chk("tmo_beat1", {c1_rdata_valid, c1_rdata, rd_timeout_err}, {1'b1, 32'hE1, 1'b0});
    for (int i = 0; i < 15; i++) begin
      step();
      chk("tmo_wait", {rd_timeout_err, c1_done, busy}, 3'b001);
    end
    step();
    chk("tmo_fire", {rd_timeout_err, c1_done, busy}, 3'b110);
    app_data_rd = 32'hE2; app_data_rd_valid = 1'b1;
    step();
    app_data_rd_valid = 1'b0;
    chk("tmo_late_drop", {c1_rdata_valid, c0_rdata_valid, rd_timeout_err, busy}, 4'b0010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
